// File: rtl/seg_seq_ctrl.sv
// seg_seq_ctrl: takes a six-digit display update request and writes it to a
// seven-segment display peripheral over APB. Writes 0..5 carry one digit each
// plus its decimal point, and write 6 carries the scan-enable control bit.
// Optional feature macro: SEG_BLINK_EN. When it is defined, a free-running
// counter periodically rewrites the control register with a toggling phase,
// which makes the display blink. When it is undefined there is no counter and
// the control register changes only on requests.
module seg_seq_ctrl #(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_digits,
  input  logic [5:0]  req_dp,
  input  logic        req_scan_en,
  output logic        done,
  output logic        busy,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [3:0]  paddr,
  output logic [31:0] pwdata
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_SETUP        = 3'd1;
  localparam logic [2:0] S_ACCESS       = 3'd2;
`ifdef SEG_BLINK_EN
  localparam logic [2:0] S_BLINK_SETUP  = 3'd3;
  localparam logic [2:0] S_BLINK_ACCESS = 3'd4;
`endif

  logic [2:0]  r_state;
  logic [2:0]  r_idx;
  logic [23:0] r_digits;
  logic [5:0]  r_dp;
  logic        r_scan;
  logic        r_ready;
  logic        r_done;
  logic        r_busy;
  logic        r_psel;
  logic        r_penable;
  logic        r_pwrite;
  logic [3:0]  r_paddr;
  logic [31:0] r_pwdata;

  logic        w_accept;
  logic [2:0]  w_next_idx;
  logic [31:0] w_first_word;
  logic [31:0] w_next_word;

  // Data word for write idx: a digit with its dot for 0..5, the control bit otherwise.
  function automatic logic [31:0] f_word(input logic [23:0] digits, input logic [5:0] dp,
                                         input logic scan, input logic [2:0] idx);
    logic [31:0] w;
    w = '0;
    case (idx)
      3'd0:    w = {24'h0, dp[0], 3'b000, digits[3:0]};
      3'd1:    w = {24'h0, dp[1], 3'b000, digits[7:4]};
      3'd2:    w = {24'h0, dp[2], 3'b000, digits[11:8]};
      3'd3:    w = {24'h0, dp[3], 3'b000, digits[15:12]};
      3'd4:    w = {24'h0, dp[4], 3'b000, digits[19:16]};
      3'd5:    w = {24'h0, dp[5], 3'b000, digits[23:20]};
      default: w = {31'h0, scan};
    endcase
    return w;
  endfunction

  assign w_accept     = (r_state == S_IDLE) && req_valid && r_ready;
  assign w_next_idx   = r_idx + 3'd1;
  assign w_first_word = f_word(req_digits, req_dp, req_scan_en, 3'd0);
  assign w_next_word  = f_word(r_digits, r_dp, r_scan, w_next_idx);

`ifdef SEG_BLINK_EN
  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_phase;
  logic             w_wrap;
  logic             w_blink_start;

  assign w_wrap        = (r_cnt == CNT_MAX);
  assign w_blink_start = (r_state == S_IDLE) && !req_valid && r_pending;

  // Free-running blink period counter, wrapping once every BLINK_CYCLES clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // One outstanding blink at most; a wrap on the service edge re-arms it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (w_wrap) begin
      r_pending <= 1'b1;
    end else if (w_blink_start) begin
      r_pending <= 1'b0;
    end
  end

  // Phase restarts lit on every new request and flips on every blink write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= 1'b1;
    end else if (w_accept) begin
      r_phase <= 1'b1;
    end else if (w_blink_start) begin
      r_phase <= ~r_phase;
    end
  end
`else
  // The plain build has no blink hardware; the period only shapes the blink build.
  if (BLINK_CYCLES < 1) begin : g_blink_cycles_unused
  end
`endif

  // Sequencer: every output is a register loaded with its value for the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_digits  <= '0;
      r_dp      <= '0;
      r_scan    <= 1'b0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_digits  <= req_digits;
            r_dp      <= req_dp;
            r_scan    <= req_scan_en;
            r_state   <= S_SETUP;
            r_idx     <= 3'd0;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b1;
            r_paddr   <= 4'd0;
            r_pwdata  <= w_first_word;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
`ifdef SEG_BLINK_EN
          else if (w_blink_start) begin
            r_state   <= S_BLINK_SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b1;
            r_paddr   <= 4'd6;
            r_pwdata  <= {31'h0, r_scan & r_phase};
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
`endif
          else begin
            r_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
        end
        S_ACCESS: begin
          if (r_idx == 3'd6) begin
            r_state   <= S_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_state   <= S_SETUP;
            r_idx     <= w_next_idx;
            r_penable <= 1'b0;
            r_paddr   <= {1'b0, w_next_idx};
            r_pwdata  <= w_next_word;
          end
        end
`ifdef SEG_BLINK_EN
        S_BLINK_SETUP: begin
          r_state   <= S_BLINK_ACCESS;
          r_penable <= 1'b1;
        end
        S_BLINK_ACCESS: begin
          r_state   <= S_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_pwrite  <= 1'b0;
          r_paddr   <= '0;
          r_pwdata  <= '0;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
        end
`endif
        default: begin
          r_state   <= S_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_pwrite  <= 1'b0;
          r_paddr   <= '0;
          r_pwdata  <= '0;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign done      = r_done;
  assign busy      = r_busy;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_seg_seq_ctrl.sv
// Testbench for seg_seq_ctrl. A transaction-level model tracks where each
// request is in its fixed 14-cycle write schedule and predicts every output on
// every cycle; directed scenarios add hand-computed literal expectations.
// Blink scenarios are included when SEG_BLINK_EN is defined.
module tb_seg_seq_ctrl;

  localparam int BC = 20;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_digits;
  logic [5:0]  req_dp;
  logic        req_scan_en;
  logic        done;
  logic        busy;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;

  typedef struct {
    int          cyc;
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t writeLog[$];
  wr_t win[$];
  int  doneLog[$];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Model state: position 1..14 inside a request's schedule, 0 when not writing.
  int          mPos = 0;
  int          mBlinkPos = 0;
  bit          mReadyOK = 0;
  bit          mDone = 0;
  bit          mAccepted = 0;
  int          mAcceptCycle = 0;
  logic [31:0] mWords[7];
  logic [31:0] mBlinkWord = '0;
`ifdef SEG_BLINK_EN
  int          mCnt = 0;
  bit          mPending = 0;
  bit          mPhase = 1;
  bit          mScan = 0;
`endif

  seg_seq_ctrl #(.BLINK_CYCLES(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_digits  (req_digits),
    .req_dp      (req_dp),
    .req_scan_en (req_scan_en),
    .done        (done),
    .busy        (busy),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [23:0] d, input logic [5:0] p, input logic s);
    req_valid   = v;
    req_digits  = d;
    req_dp      = p;
    req_scan_en = s;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic modelStep();
    bit wasIdle;
`ifdef SEG_BLINK_EN
    bit wrap;
    bit startBlink;
`endif
    mAccepted = 0;
    if (rst) begin
      mPos = 0;
      mBlinkPos = 0;
      mReadyOK = 0;
      mDone = 0;
`ifdef SEG_BLINK_EN
      mCnt = 0;
      mPending = 0;
      mPhase = 1;
      mScan = 0;
`endif
      return;
    end
    wasIdle = (mPos == 0) && (mBlinkPos == 0);
    mDone = 0;
`ifdef SEG_BLINK_EN
    startBlink = 0;
    wrap = (mCnt == BC - 1);
    mCnt = wrap ? 0 : mCnt + 1;
`endif
    if (wasIdle) begin
      if (req_valid && mReadyOK) begin
        for (int i = 0; i < 6; i++) mWords[i] = {24'h0, req_dp[i], 3'b000, req_digits[4*i +: 4]};
        mWords[6] = {31'h0, req_scan_en};
        mPos = 1;
        mReadyOK = 0;
        mAccepted = 1;
        // Spec cycle 0 is the cycle whose closing edge accepted the request.
        mAcceptCycle = cycle - 1;
`ifdef SEG_BLINK_EN
        mPhase = 1;
        mScan = req_scan_en;
`endif
      end
`ifdef SEG_BLINK_EN
      else if (!req_valid && mPending) begin
        startBlink = 1;
        mBlinkPos = 1;
        mBlinkWord = {31'h0, mScan & mPhase};
        mPhase = !mPhase;
        mReadyOK = 0;
      end
`endif
      else begin
        mReadyOK = 1;
      end
    end else if (mPos == 14) begin
      mPos = 0;
      mDone = 1;
      mReadyOK = 1;
    end else if (mPos != 0) begin
      mPos++;
    end else if (mBlinkPos == 1) begin
      mBlinkPos = 2;
    end else begin
      mBlinkPos = 0;
      mReadyOK = 1;
    end
`ifdef SEG_BLINK_EN
    mPending = wrap ? 1'b1 : (startBlink ? 1'b0 : mPending);
`endif
  endtask

  // Compare every DUT output against the model's prediction for this cycle.
  task automatic compareAll();
    bit          eIdle;
    bit          eEnable;
    logic [3:0]  eAddr;
    logic [31:0] eData;
    eIdle = (mPos == 0) && (mBlinkPos == 0);
    eEnable = 0;
    eAddr = '0;
    eData = '0;
    if (mPos != 0) begin
      eAddr = 4'((mPos - 1) / 2);
      eData = mWords[(mPos - 1) / 2];
      eEnable = (mPos % 2 == 0);
    end else if (mBlinkPos != 0) begin
      eAddr = 4'd6;
      eData = mBlinkWord;
      eEnable = (mBlinkPos == 2);
    end
    checkOutput("psel", 32'(psel), 32'(!eIdle));
    checkOutput("penable", 32'(penable), 32'(eEnable));
    checkOutput("pwrite", 32'(pwrite), 32'(!eIdle));
    checkOutput("paddr", 32'(paddr), 32'(eAddr));
    checkOutput("pwdata", pwdata, eData);
    checkOutput("busy", 32'(busy), 32'(!eIdle));
    checkOutput("req_ready", 32'(req_ready), 32'(eIdle && mReadyOK));
    checkOutput("done", 32'(done), 32'(mDone));
  endtask

  // Model update on each edge, then a check 1 unit later, plus write/done logging.
  always @(posedge clk) begin
    cycle++;
    modelStep();
    #1;
    compareAll();
    if (psel && penable) writeLog.push_back('{cycle, paddr, pwdata});
    if (done) doneLog.push_back(cycle);
  end

  function automatic void pickWindow(input int lo, input int hi);
    win.delete();
    foreach (writeLog[k]) begin
      if (writeLog[k].cyc >= lo && writeLog[k].cyc <= hi) win.push_back(writeLog[k]);
    end
  endfunction

  task automatic waitAccept(input string name, output int base);
    int n;
    n = 0;
    base = cycle;
    do begin
      @(negedge clk);
      n++;
    end while (!mAccepted && n < 60);
    if (!mAccepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: no acceptance within %0d cycles, expected acceptance", name, n);
    end else begin
      base = mAcceptCycle;
    end
  endtask

  // Hard stop in case something hangs.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, expected summary before it");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int base;
    int base2;
    int rstCycle;
    int doneAfter;
    logic [31:0] expD[7];
    expD = '{32'h86, 32'h05, 32'h04, 32'h03, 32'h02, 32'h01, 32'h01};

    rst = 1'b1;
    applyStimulus(0, 24'h0, 6'h0, 0);
    @(negedge clk);
    checkOutput("reset psel", 32'(psel), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset pwdata", pwdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready after release", 32'(req_ready), 32'h1);

    // Single request with known digits.
    writeLog.delete();
    doneLog.delete();
    applyStimulus(1, 24'h123456, 6'b000001, 1);
    waitAccept("accept A", base);
    req_valid = 1'b0;
    repeat (16) @(negedge clk);
    pickWindow(base + 1, base + 14);
    checkOutput("A write count", 32'(win.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < win.size()) begin
        checkOutput($sformatf("A addr %0d", i), 32'(win[i].a), 32'(i));
        checkOutput($sformatf("A data %0d", i), win[i].d, expD[i]);
        checkOutput($sformatf("A access cycle %0d", i), 32'(win[i].cyc - base), 32'(2 * i + 2));
      end
    end
    checkOutput("A done count", 32'(doneLog.size()), 32'd1);
    if (doneLog.size() > 0) checkOutput("A done cycle", 32'(doneLog[0] - base), 32'd15);

    // Two requests back to back with valid held high throughout.
    applyStimulus(1, 24'hFEDCBA, 6'b101010, 0);
    waitAccept("accept B1", base);
    applyStimulus(1, 24'h0F1E2D, 6'b010101, 1);
    waitAccept("accept B2", base2);
    req_valid = 1'b0;
    checkOutput("B second accept offset", 32'(base2 - base), 32'd15);
    repeat (16) @(negedge clk);
    pickWindow(base + 1, base + 14);
    if (win.size() > 0) checkOutput("B1 first data", win[0].d, 32'h0A);
    pickWindow(base + 15, base + 30);
    checkOutput("B2 write count", 32'(win.size()), 32'd7);
    if (win.size() > 0) begin
      checkOutput("B2 first access cycle", 32'(win[0].cyc - base), 32'd17);
      checkOutput("B2 first addr", 32'(win[0].a), 32'h0);
      checkOutput("B2 first data", win[0].d, 32'h8D);
    end

    // Reset in the middle of a sequence.
    applyStimulus(1, 24'h777777, 6'b111111, 1);
    waitAccept("accept C", base);
    req_valid = 1'b0;
    while (cycle < base + 7) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("C rst psel", 32'(psel), 32'h0);
    checkOutput("C rst penable", 32'(penable), 32'h0);
    checkOutput("C rst pwrite", 32'(pwrite), 32'h0);
    checkOutput("C rst paddr", 32'(paddr), 32'h0);
    checkOutput("C rst pwdata", pwdata, 32'h0);
    checkOutput("C rst busy", 32'(busy), 32'h0);
    checkOutput("C rst req_ready", 32'(req_ready), 32'h0);
    rstCycle = cycle;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    pickWindow(rstCycle + 1, cycle);
    checkOutput("C writes after reset", 32'(win.size()), 32'd0);
    doneAfter = 0;
    foreach (doneLog[k]) if (doneLog[k] > base) doneAfter++;
    checkOutput("C done after reset", 32'(doneAfter), 32'd0);
    applyStimulus(1, 24'hABCDEF, 6'b100000, 0);
    waitAccept("accept C2", base);
    req_valid = 1'b0;
    repeat (16) @(negedge clk);
    pickWindow(base + 1, base + 14);
    checkOutput("C2 write count", 32'(win.size()), 32'd7);
    if (win.size() == 7) begin
      checkOutput("C2 first addr", 32'(win[0].a), 32'h0);
      checkOutput("C2 first data", win[0].d, 32'h0F);
      checkOutput("C2 dp data", win[5].d, 32'h8A);
      checkOutput("C2 ctrl data", win[6].d, 32'h0);
    end

`ifdef SEG_BLINK_EN
    // Idle after a scan-enabled request: control writes must alternate 1,0,1,...
    applyStimulus(1, 24'h000000, 6'b000000, 1);
    waitAccept("accept D", base);
    req_valid = 1'b0;
    doneLog.delete();
    repeat (110) @(negedge clk);
    pickWindow(base + 15, cycle);
    checkOutput("D blink count ok", 32'(win.size() >= 4), 32'h1);
    for (int i = 0; i < win.size(); i++) begin
      checkOutput($sformatf("D blink addr %0d", i), 32'(win[i].a), 32'h6);
      checkOutput($sformatf("D blink data %0d", i), win[i].d, (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    doneAfter = 0;
    foreach (doneLog[k]) if (doneLog[k] > base + 15) doneAfter++;
    checkOutput("D no done during blink", 32'(doneAfter), 32'd0);
`endif

    // Random traffic: requests held until accepted, random gaps between them.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (mAccepted || !req_valid) begin
        if ($urandom_range(0, 2) == 0)
          applyStimulus(1, 24'($urandom), 6'($urandom), 1'($urandom));
        else
          req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
